// File: rtl/led_ctrl_pkg.sv
// Shared register map and address decode for the LED controller.
// Blink logic is built only when LED_CTRL_BLINK_EN is defined.
package led_ctrl_pkg;

   localparam logic [31:0] ADDR_VER    = 32'h0000_0000;
   localparam logic [31:0] ADDR_VAL    = 32'h0000_0004;
   localparam logic [31:0] ADDR_MODE   = 32'h0000_0008;
   localparam logic [31:0] ADDR_PERIOD = 32'h0000_000C;
   localparam logic [31:0] ADDR_STATUS = 32'h0000_0010;

   localparam logic [31:0] HW_VER = 32'h0000_0002;

   localparam int LED_N = 4;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_VER,
      SEL_VAL,
      SEL_MODE,
      SEL_PERIOD,
      SEL_STATUS
   } reg_sel_e;

   // Full 32-bit compare: aliases of the map are unmapped.
   function automatic reg_sel_e decode_addr(input logic [31:0] addr);
      reg_sel_e sel;
      sel = SEL_NONE;
      case (addr)
         ADDR_VER:    sel = SEL_VER;
         ADDR_VAL:    sel = SEL_VAL;
         ADDR_MODE:   sel = SEL_MODE;
         ADDR_PERIOD: sel = SEL_PERIOD;
         ADDR_STATUS: sel = SEL_STATUS;
         default:     sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Half-period counter and blink phase for the LED controller.
// Only instantiated when LED_CTRL_BLINK_EN is defined.
module led_blink_timer
   import led_ctrl_pkg::*;
#(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] period,
   input  logic             period_wr,
   output logic             phase
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             phase_nxt;
   logic             wrap;

   assign wrap = (period != '0) && (cnt == period - CNT_W'(1));

   // A PERIOD write restarts the half-period so a shrink never skips a wrap.
   always_comb begin
      cnt_nxt   = cnt;
      phase_nxt = phase;
      if (period_wr) begin
         cnt_nxt = '0;
      end else if (period == '0) begin
         cnt_nxt = '0;
      end else if (wrap) begin
         cnt_nxt   = '0;
         phase_nxt = ~phase;
      end else begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         phase <= phase_nxt;
      end
   end

endmodule

// File: rtl/led_ctrl.sv
// Memory-mapped 4-LED controller with optional blink support.
// Blink mode, PERIOD and phase exist only with LED_CTRL_BLINK_EN.
module led_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int CNT_W = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr,
   input  logic [31:0] waddr,
   input  logic [31:0] wdata,
   input  logic        rd,
   input  logic [31:0] raddr,
   output logic [31:0] rdata,
   output logic [3:0]  led_pin
);

   reg_sel_e         wsel;
   reg_sel_e         rsel;
   logic [LED_N-1:0] val;
   logic [LED_N-1:0] next_pin;
   logic [31:0]      mode_rd;
   logic [31:0]      period_rd;
   logic [31:0]      rmux;
   logic             phase;
   logic             wen_val;
   logic             unused_wdata;

   assign wsel    = decode_addr(waddr);
   assign rsel    = decode_addr(raddr);
   assign wen_val = wr && (wsel == SEL_VAL);

   assign unused_wdata = ^wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         val <= '0;
      end else if (wen_val) begin
         val <= wdata[LED_N-1:0];
      end
   end

`ifdef LED_CTRL_BLINK_EN

   logic [LED_N-1:0] mode;
   logic [CNT_W-1:0] period;
   logic             wen_mode;
   logic             wen_period;

   assign wen_mode   = wr && (wsel == SEL_MODE);
   assign wen_period = wr && (wsel == SEL_PERIOD);

   always_ff @(posedge clk) begin
      if (rst) begin
         mode   <= '0;
         period <= '0;
      end else begin
         if (wen_mode) begin
            mode <= wdata[LED_N-1:0];
         end
         if (wen_period) begin
            period <= wdata[CNT_W-1:0];
         end
      end
   end

   led_blink_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .period   (period),
      .period_wr(wen_period),
      .phase    (phase)
   );

   always_comb begin
      mode_rd = '0;
      mode_rd[LED_N-1:0] = mode;
   end

   always_comb begin
      period_rd = '0;
      period_rd[CNT_W-1:0] = period;
   end

   always_comb begin
      next_pin = '0;
      for (int i = 0; i < LED_N; i++) begin
         next_pin[i] = mode[i] ? (val[i] & phase) : val[i];
      end
   end

`else

   assign phase     = 1'b0;
   assign mode_rd   = '0;
   assign period_rd = '0;
   assign next_pin  = val;

`endif

   // Read mux sees pre-edge state, so a same-cycle write is not visible.
   always_comb begin
      rmux = '0;
      case (rsel)
         SEL_VER:    rmux = HW_VER;
         SEL_VAL:    rmux = {28'h0, val};
         SEL_MODE:   rmux = mode_rd;
         SEL_PERIOD: rmux = period_rd;
         SEL_STATUS: rmux = {27'h0, phase, led_pin};
         default:    rmux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata   <= '0;
         led_pin <= '0;
      end else begin
         if (rd) begin
            rdata <= rmux;
         end
         led_pin <= next_pin;
      end
   end

endmodule
